// File: rtl/mmac_pkg.sv
// Shared parameters, state encoding and buffer indexing for the 4x4 matrix MAC sequencer.
package mmac_pkg;

  localparam int M_SIZE         = 4;
  localparam int VAR_WIDTH      = 4;
  localparam int DATA_WIDTH     = 16;
  localparam int IDX_WIDTH      = $clog2(M_SIZE);
  localparam int N_ELEM         = M_SIZE * M_SIZE;
  localparam int LOAD_BEATS     = 2 * N_ELEM;
  localparam int LOAD_CNT_WIDTH = $clog2(LOAD_BEATS) + 1;
  localparam int ACC_WIDTH      = DATA_WIDTH;
  localparam int BUF_AW         = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    COMP = 2'd2,
    OUT  = 2'd3
  } mmac_state_t;

  // Row-major position of element [r][c] inside a flat operand buffer.
  function automatic logic [BUF_AW-1:0] flat_idx(input logic [IDX_WIDTH-1:0] r,
                                                 input logic [IDX_WIDTH-1:0] c);
    return BUF_AW'(r) * BUF_AW'(M_SIZE) + BUF_AW'(c);
  endfunction

endpackage

// File: rtl/mmac_seq_if.sv
// Operand-in / result-out streaming bus of the matrix MAC sequencer.
// Both directions: a beat transfers on a rising edge where valid && ready; the
// sender keeps valid and data stable until that edge, ready never waits on valid.
interface mmac_seq_if;
  import mmac_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [VAR_WIDTH-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/mmac_pe.sv
// Single multiply-accumulate slice; o_acc is the running sum including this cycle's product.
module mmac_pe
  import mmac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [VAR_WIDTH-1:0] i_a,
  input  logic [VAR_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0] o_acc
);

  logic [2*VAR_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]   w_base;
  logic [ACC_WIDTH-1:0]   r_acc;

  assign w_prod = {{VAR_WIDTH{1'b0}}, i_a} * {{VAR_WIDTH{1'b0}}, i_b};
  // Clearing loads the product directly, so the first term needs no extra cycle.
  assign w_base = i_clr ? '0 : r_acc;
  assign o_acc  = w_base + ACC_WIDTH'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc;
    end
  end

endmodule

// File: rtl/mmac_seq.sv
// Loads A and B, walks the i/j/k loop nest of C = A*B through one MAC slice and
// streams the C elements out row-major; all outputs come straight from flops.
module mmac_seq
  import mmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  mmac_seq_if.slave   bus,
  output logic        busy,
  output logic        done,
  output mmac_state_t o_state
);

  mmac_state_t               r_state;
  mmac_state_t               w_next_state;
  logic [LOAD_CNT_WIDTH-1:0] r_load_cnt;
  logic [IDX_WIDTH-1:0]      r_i;
  logic [IDX_WIDTH-1:0]      r_j;
  logic [IDX_WIDTH-1:0]      r_k;
  logic [VAR_WIDTH-1:0]      r_a_buf [N_ELEM];
  logic [VAR_WIDTH-1:0]      r_b_buf [N_ELEM];
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_start_job;
  logic                      w_load_beat;
  logic                      w_pe_en;
  logic                      w_out_hs;
  logic                      w_load_last;
  logic                      w_k_last;
  logic                      w_j_last;
  logic                      w_last_elem;
  logic                      w_load_to_a;
  logic [BUF_AW-1:0]         w_buf_addr;
  logic [VAR_WIDTH-1:0]      w_a_op;
  logic [VAR_WIDTH-1:0]      w_b_op;
  logic [ACC_WIDTH-1:0]      w_acc;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_start_job) w_next_state = LOAD;
      LOAD: if (w_load_beat && w_load_last) w_next_state = COMP;
      COMP: if (w_k_last) w_next_state = OUT;
      OUT:  if (w_out_hs) w_next_state = w_last_elem ? IDLE : COMP;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM per-state control strobes
  always_comb begin
    w_start_job = 1'b0;
    w_load_beat = 1'b0;
    w_pe_en     = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      IDLE: w_start_job = start;
      LOAD: w_load_beat = bus.in_valid && r_in_ready;
      COMP: w_pe_en     = 1'b1;
      OUT:  w_out_hs    = bus.out_ready && r_out_valid;
      default: ;
    endcase
  end

  assign w_load_last = (r_load_cnt == LOAD_CNT_WIDTH'(LOAD_BEATS - 1));
  assign w_k_last    = (r_k == IDX_WIDTH'(M_SIZE - 1));
  assign w_j_last    = (r_j == IDX_WIDTH'(M_SIZE - 1));
  assign w_last_elem = w_j_last && (r_i == IDX_WIDTH'(M_SIZE - 1));

  // The first N_ELEM beats fill A, the rest fill B, each row-major.
  assign w_load_to_a = (r_load_cnt < LOAD_CNT_WIDTH'(N_ELEM));
  assign w_buf_addr  = w_load_to_a ? BUF_AW'(r_load_cnt)
                                   : BUF_AW'(r_load_cnt - LOAD_CNT_WIDTH'(N_ELEM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_ELEM; n++) begin
        r_a_buf[n] <= '0;
        r_b_buf[n] <= '0;
      end
    end else if (w_load_beat) begin
      if (w_load_to_a) begin
        r_a_buf[w_buf_addr] <= bus.in_data;
      end else begin
        r_b_buf[w_buf_addr] <= bus.in_data;
      end
    end
  end

  assign w_a_op = r_a_buf[flat_idx(r_i, r_k)];
  assign w_b_op = r_b_buf[flat_idx(r_k, r_j)];

  mmac_pe u_pe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_k == '0),
    .i_en  (w_pe_en),
    .i_a   (w_a_op),
    .i_b   (w_b_op),
    .o_acc (w_acc)
  );

  // Loop counters: k runs inside COMP, (i,j) advance on each accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
    end else begin
      if (w_start_job) begin
        r_load_cnt <= '0;
        r_i        <= '0;
        r_j        <= '0;
        r_k        <= '0;
      end
      if (w_load_beat) begin
        r_load_cnt <= r_load_cnt + LOAD_CNT_WIDTH'(1);
      end
      if (w_pe_en) begin
        r_k <= w_k_last ? '0 : r_k + IDX_WIDTH'(1);
      end
      if (w_out_hs) begin
        r_j <= w_j_last ? '0 : r_j + IDX_WIDTH'(1);
        if (w_j_last) begin
          r_i <= r_i + IDX_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == LOAD);
      r_out_valid <= (w_next_state == OUT);
      r_out_last  <= (w_next_state == OUT) && w_last_elem;
      r_busy      <= (w_next_state != IDLE);
      r_done      <= w_out_hs && w_last_elem;
      if (w_pe_en && w_k_last) begin
        r_out_data <= DATA_WIDTH'(w_acc);
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign o_state       = r_state;

endmodule

// File: tb/tb_mmac_seq.sv
// Bench for mmac_seq: table of jobs plus hand-built corner sequences, results
// checked against a plain matrix-product model through an expected queue.
module tb_mmac_seq;
  import mmac_pkg::*;

  localparam int P_ID = 0, P_RAMP = 1, P_15 = 2, P_ONE = 3, P_RND = 4;
  localparam int R_HIGH = 0, R_STALL3 = 1, R_RND = 2;
  localparam int V_CONT = 0, V_TOG = 1, V_RND = 2;

  typedef struct {
    int pa;
    int pb;
    int rmode;
    int vmode;
    int exp_done;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  mmac_state_t state;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmac_seq_if bus();

  mmac_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .o_state (state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_WIDTH:0]  exp_q[$];
  logic [VAR_WIDTH-1:0] ma [N_ELEM];
  logic [VAR_WIDTH-1:0] mb [N_ELEM];
  int rdy_mode = R_HIGH;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int pat_val(input int pat, input int r, input int c);
    case (pat)
      P_ID:    return (r == c) ? 1 : 0;
      P_RAMP:  return (4 * r + c) % 16;
      P_15:    return 15;
      P_ONE:   return 1;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  // C = A*B by definition; each result tagged with whether it is the final element.
  task automatic build_model(input int pa, input int pb);
    int sum;
    for (int r = 0; r < M_SIZE; r++)
      for (int c = 0; c < M_SIZE; c++) begin
        ma[r * M_SIZE + c] = VAR_WIDTH'(pat_val(pa, r, c));
        mb[r * M_SIZE + c] = VAR_WIDTH'(pat_val(pb, r, c));
      end
    for (int i = 0; i < M_SIZE; i++)
      for (int j = 0; j < M_SIZE; j++) begin
        sum = 0;
        for (int k = 0; k < M_SIZE; k++)
          sum += int'(ma[i * M_SIZE + k]) * int'(mb[k * M_SIZE + j]);
        exp_q.push_back({(i == M_SIZE - 1) && (j == M_SIZE - 1), DATA_WIDTH'(sum)});
      end
  endtask

  // Output monitor: drives out_ready and checks every accepted beat.
  initial begin : monitor
    logic [DATA_WIDTH:0]   e;
    logic [DATA_WIDTH-1:0] held_data;
    bit held;
    int stall_cnt;
    held = 0;
    stall_cnt = 0;
    held_data = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
        stall_cnt = 0;
      end else begin
        if (held && bus.out_valid) check("out_data_stable", bus.out_data, held_data);
        case (rdy_mode)
          R_HIGH:   bus.out_ready = 1'b1;
          R_STALL3: bus.out_ready = bus.out_valid && (stall_cnt >= 3);
          default:  bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus.out_valid) begin
          if (bus.out_ready) begin
            check("exp_available", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("out_data", bus.out_data, e[DATA_WIDTH-1:0]);
              check("out_last", bus.out_last, e[DATA_WIDTH]);
            end
            held = 0;
            stall_cnt = 0;
          end else begin
            held = 1;
            held_data = bus.out_data;
            stall_cnt++;
          end
        end else begin
          held = 0;
          check("out_last_idle", bus.out_last, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},  bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_state"},     state, IDLE);
  endtask

  task automatic do_reset(input string tag);
    start = 1'b0;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero({tag, "_rst_now"});
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_zero({tag, "_rst_hold"});
    rst_n = 1'b1;
  endtask

  task automatic run_job(input vec_t v, input int mid_start, input bit skip_start,
                         input bit start_on_done, input int abort_cyc, input string tag);
    int c0, beat, n, dcyc;
    bit acc, seen;
    build_model(v.pa, v.pb);
    rdy_mode = v.rmode;
    c0 = 0;
    dcyc = 0;
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1;
      c0 = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    if (skip_start) c0 = cyc - 1;
    check({tag, "_in_ready_c1"}, bus.in_ready, 1);
    check({tag, "_busy_c1"}, busy, 1);

    beat = 0;
    n = 0;
    while (beat < LOAD_BEATS && n < 1000) begin
      case (v.vmode)
        V_CONT:  bus.in_valid = 1'b1;
        V_TOG:   bus.in_valid = ((cyc - c0) % 2) == 1;
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = (beat < N_ELEM) ? ma[beat] : mb[beat - N_ELEM];
      check({tag, "_in_ready_load"}, bus.in_ready, 1);
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      n++;
      if (acc) beat++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_load_beats"}, beat, LOAD_BEATS);
    check({tag, "_in_ready_after"}, bus.in_ready, 0);

    seen = 0;
    n = 0;
    while (!seen && n < 3000) begin
      start = (mid_start > 0) && (cyc - c0 == mid_start);
      if (abort_cyc > 0 && cyc - c0 == abort_cyc) begin
        do_reset(tag);
        return;
      end
      if (done) begin
        seen = 1;
        dcyc = cyc - c0;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      if (v.exp_done >= 0) check({tag, "_done_cycle"}, dcyc, v.exp_done);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_queue_drained"}, exp_q.size(), 0);
      if (start_on_done) begin
        start = 1'b1;
      end else begin
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_after"}, state, IDLE);
      end
    end
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    vec_t vecs[7];
    vec_t v;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_por", state, IDLE);

    vecs[0] = '{P_ID,  P_RAMP, R_HIGH,   V_CONT, 113};
    vecs[1] = '{P_15,  P_15,   R_HIGH,   V_CONT, 113};
    vecs[2] = '{P_ID,  P_RAMP, R_STALL3, V_CONT, 161};
    vecs[3] = '{P_ID,  P_RAMP, R_HIGH,   V_TOG,  144};
    vecs[4] = '{P_RND, P_RND,  R_RND,    V_RND,  -1};
    vecs[5] = '{P_RND, P_RND,  R_STALL3, V_RND,  -1};
    vecs[6] = '{P_RND, P_RND,  R_RND,    V_CONT, -1};
    for (int t = 0; t < 7; t++) run_job(vecs[t], 0, 1'b0, 1'b0, 0, $sformatf("vec%0d", t));

    // start pulsed mid-job is dropped; start in the done cycle chains a new job
    v = '{P_ID, P_RAMP, R_HIGH, V_CONT, 113};
    run_job(v, 50, 1'b0, 1'b1, 0, "midstart");
    v = '{P_15, P_RND, R_HIGH, V_CONT, 113};
    run_job(v, 0, 1'b1, 1'b0, 0, "chained");

    // reset while in COMP, then a clean all-ones job
    v = '{P_RND, P_RND, R_HIGH, V_CONT, -1};
    run_job(v, 0, 1'b0, 1'b0, 40, "abort");
    @(negedge clk);
    check("idle_after_abort", state, IDLE);
    v = '{P_ONE, P_ONE, R_HIGH, V_CONT, 113};
    run_job(v, 0, 1'b0, 1'b0, 0, "after_rst");

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
